// File: rtl/fpga_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_reg_bank_pkg
//  Description : Shared register indices and default sizing for the
//                fpga_reg_bank register block.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpga_reg_bank_pkg;

  localparam int          DATA_WIDTH_DEF = 32;
  localparam int          REGISTER_N_DEF = 6;
  localparam logic [31:0] VERSION_DEF    = 32'h0001_0000;

  localparam int CTRL_IDX    = 0;
  localparam int PULSE_IDX   = 1;
  localparam int STATUS_IDX  = 2;
  localparam int EVT_CNT_IDX = 3;
  localparam int SCRATCH_IDX = 4;
  localparam int VERSION_IDX = 5;

endpackage : fpga_reg_bank_pkg
`default_nettype wire

// File: rtl/byte_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_merge
//  Description : Replaces the byte lanes of old_val selected by strobe with
//                the matching lanes of wr_data; unselected lanes pass through.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_val,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] strobe,
  output logic [DATA_WIDTH-1:0]   new_val
);

  localparam int c_BYTES = DATA_WIDTH / 8;

  // One mux per byte lane, selected by that lane's strobe bit
  for (genvar g_b = 0; g_b < c_BYTES; g_b++) begin : g_lane
    assign new_val[g_b*8 +: 8] = strobe[g_b] ? wr_data[g_b*8 +: 8] : old_val[g_b*8 +: 8];
  end

endmodule : byte_lane_merge
`default_nettype wire

// File: rtl/fpga_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_reg_bank
//  Description : Six-entry control/status register bank: CTRL (RW), PULSE
//                (write-pulse), STATUS (sticky, W1C), EVT_CNT (saturating,
//                clear-on-read), SCRATCH (RW), VERSION (RO constant).
//  Revision    : 1.0 - initial release
// ============================================================================
module fpga_reg_bank
  import fpga_reg_bank_pkg::*;
#(
  parameter int          DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int          REGISTER_N = REGISTER_N_DEF,
  parameter logic [31:0] VERSION    = VERSION_DEF
) (
  input  logic                                    S_AXI_ACLK,
  input  logic                                    S_AXI_ARESETN,
  input  logic [DATA_WIDTH-1:0]                   reg_wrdout,
  input  logic [REGISTER_N-1:0][DATA_WIDTH/8-1:0] reg_wrByteStrobe,
  input  logic [REGISTER_N-1:0]                   reg_rdStrobe,
  output logic [REGISTER_N-1:0][DATA_WIDTH-1:0]   reg_rddin,
  output logic [DATA_WIDTH-1:0]                   ctrl_o,
  output logic [DATA_WIDTH-1:0]                   pulse_o,
  input  logic [DATA_WIDTH-1:0]                   status_set_i,
  input  logic                                    event_i
);

  localparam int              c_BYTES   = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] c_VERSION = DATA_WIDTH'(VERSION);

  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_pulse;
  logic [DATA_WIDTH-1:0] r_status;
  logic [DATA_WIDTH-1:0] r_evt_cnt;
  logic [DATA_WIDTH-1:0] r_scratch;

  logic [DATA_WIDTH-1:0] w_ctrl_next;
  logic [DATA_WIDTH-1:0] w_scratch_next;
  logic [DATA_WIDTH-1:0] w_pulse_mask;
  logic [DATA_WIDTH-1:0] w_status_mask;
  logic                  w_unused;

  // Read strobes other than EVT_CNT and writes to read-only entries are ignored
  assign w_unused = ^{reg_rdStrobe, reg_wrByteStrobe[EVT_CNT_IDX], reg_wrByteStrobe[VERSION_IDX]};

  // Expand byte strobes to bit masks for the bitwise-acting registers
  for (genvar g_b = 0; g_b < c_BYTES; g_b++) begin : g_mask
    assign w_pulse_mask[g_b*8 +: 8]  = {8{reg_wrByteStrobe[PULSE_IDX][g_b]}};
    assign w_status_mask[g_b*8 +: 8] = {8{reg_wrByteStrobe[STATUS_IDX][g_b]}};
  end

  byte_lane_merge #(.DATA_WIDTH(DATA_WIDTH)) u_ctrl_merge (
    .old_val (r_ctrl),
    .wr_data (reg_wrdout),
    .strobe  (reg_wrByteStrobe[CTRL_IDX]),
    .new_val (w_ctrl_next)
  );

  byte_lane_merge #(.DATA_WIDTH(DATA_WIDTH)) u_scratch_merge (
    .old_val (r_scratch),
    .wr_data (reg_wrdout),
    .strobe  (reg_wrByteStrobe[SCRATCH_IDX]),
    .new_val (w_scratch_next)
  );

  // Register state: byte-merged RW regs, one-cycle pulses, sticky status, event counter
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_ctrl    <= '0;
      r_pulse   <= '0;
      r_status  <= '0;
      r_evt_cnt <= '0;
      r_scratch <= '0;
    end else begin
      r_ctrl    <= w_ctrl_next;
      r_scratch <= w_scratch_next;
      r_pulse   <= reg_wrdout & w_pulse_mask;
      // Set is OR-ed after the clear so a simultaneous set wins
      r_status  <= (r_status & ~(reg_wrdout & w_status_mask)) | status_set_i;
      if (reg_rdStrobe[EVT_CNT_IDX]) begin
        r_evt_cnt <= event_i ? DATA_WIDTH'(1) : '0;
      end else if (event_i && (r_evt_cnt != '1)) begin
        r_evt_cnt <= r_evt_cnt + DATA_WIDTH'(1);
      end
    end
  end

  // Combinational read view of current register state
  always_comb begin
    reg_rddin              = '0;
    reg_rddin[CTRL_IDX]    = r_ctrl;
    reg_rddin[PULSE_IDX]   = '0;
    reg_rddin[STATUS_IDX]  = r_status;
    reg_rddin[EVT_CNT_IDX] = r_evt_cnt;
    reg_rddin[SCRATCH_IDX] = r_scratch;
    reg_rddin[VERSION_IDX] = c_VERSION;
  end

  assign ctrl_o  = r_ctrl;
  assign pulse_o = r_pulse;

endmodule : fpga_reg_bank
`default_nettype wire

// File: doc/fpga_reg_bank.md
FPGA_REG_BANK -- requirements
Module: fpga_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits (multiple of 8).
REQ-002 SHALL have parameter REGISTER_N, default 6, number of registers; fixed map below requires exactly 6.
REQ-003 SHALL have parameter VERSION, default 32'h0001_0000, constant returned by the VERSION register.
REQ-004 SHALL have port S_AXI_ACLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port S_AXI_ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port reg_wrdout  input  DATA_WIDTH  write data shared by all registers.
REQ-007 SHALL have port reg_wrByteStrobe  input  [REGISTER_N] x DATA_WIDTH/8  per-register byte-lane write enables; any non-zero entry is a write to that register.
REQ-008 SHALL have port reg_rdStrobe  input  [REGISTER_N] x 1  one-cycle read indication per register.
REQ-009 SHALL have port reg_rddin  output  [REGISTER_N] x DATA_WIDTH  current value of each register.
REQ-010 SHALL have port ctrl_o  output  DATA_WIDTH  contents of CTRL.
REQ-011 SHALL have port pulse_o  output  DATA_WIDTH  one-cycle command pulses.
REQ-012 SHALL have port status_set_i  input  DATA_WIDTH  per-bit sticky-status set requests.
REQ-013 SHALL have port event_i  input  1  event to count, one per high cycle.

Function
REQ-014 Register map SHALL be: 0 CTRL (RW), 1 PULSE (W, reads 0), 2 STATUS (W1C), 3 EVT_CNT (RO, clear-on-read), 4 SCRATCH (RW), 5 VERSION (RO).
REQ-015 CTRL and SCRATCH SHALL update only the byte lanes whose strobe bit is 1, at the clock edge where the strobe is seen; other lanes hold.
REQ-016 reg_rddin SHALL be a combinational view of register state: a write is visible the cycle after its strobe, never the same cycle.
REQ-017 ctrl_o SHALL equal the CTRL register at all times.
REQ-018 PULSE write SHALL drive pulse_o bit n high for exactly one cycle (the cycle after the strobe) for each written 1 in an enabled lane; otherwise pulse_o = 0; back-to-back writes give back-to-back pulses.
REQ-019 STATUS bit n SHALL set when status_set_i[n]=1 and clear when written 1 in an enabled lane; simultaneous set and clear: set wins.
REQ-020 EVT_CNT SHALL increment by 1 per cycle with event_i=1 and saturate at all-ones (no wrap).
REQ-021 reg_rdStrobe[3] SHALL return the pre-clear count that cycle and clear EVT_CNT at that edge; simultaneous event_i: next value 1.
REQ-022 Writes to EVT_CNT and VERSION SHALL be ignored; VERSION reads return parameter VERSION.
REQ-023 reg_rdStrobe SHALL have no effect on any register other than EVT_CNT.
REQ-024 Strobes to several registers in one cycle SHALL each take effect independently.

Reset
REQ-025 Asserting S_AXI_ARESETN low SHALL immediately force CTRL, STATUS, EVT_CNT, SCRATCH, pulse_o to 0, including mid-pulse or mid-count.
REQ-026 Reset SHALL release synchronously to the first rising edge with S_AXI_ARESETN high; no write or event is captured while low.

Structure
REQ-027 Register indices (CTRL_IDX..VERSION_IDX), REGISTER_N and DATA_WIDTH defaults SHALL live in shared package fpga_reg_bank_pkg.
REQ-028 Byte-lane merge (old value, write data, strobe -> new value) SHALL be one sub-module, byte_lane_merge, reused by CTRL and SCRATCH.

Verification
REQ-029 Write CTRL 32'hAABBCCDD strobe 4'hF, then 32'h11223344 strobe 4'b0101 -> ctrl_o = 32'hAA22CC44 one cycle after second write.
REQ-030 Write PULSE 32'h0000_0005 -> pulse_o = 32'h5 for exactly one cycle, then 0; reg_rddin[1] stays 0.
REQ-031 status_set_i = 32'h3 one cycle, then write STATUS 32'h1 while status_set_i=32'h1 -> STATUS reads 32'h3; next W1C 32'h1 with no set -> 32'h2.
REQ-032 Ten event_i cycles, then rdStrobe[3] with event_i=1 -> reg_rddin[3] = 10 that cycle, 1 next cycle.
REQ-033 Preload EVT_CNT near saturation (force or long run), continue events -> holds 32'hFFFF_FFFF; write to EVT_CNT/VERSION -> no change.
REQ-034 Assert reset mid-pulse and mid-count -> all RW/counter/pulse outputs 0 asynchronously; VERSION still returns parameter.
